// File: rtl/fetch_seq_if.sv
// Bus between the fetch sequencer and its control/PC environment.
// imem_req is a valid with no ready: pcnext_out is a real fetch address only while imem_req=1, and the fetch side accepts it every cycle.
interface fetch_seq_if;
    logic [15:0] pc_in;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_off;
    logic        jump;
    logic        call;
    logic [15:0] jump_target;
    logic        ret;
    logic        halt;
    logic [15:0] pcnext_out;
    logic        imem_req;
    logic        done;
    logic        ras_overflow;
    logic        ras_underflow;
    logic [1:0]  state_dbg;
    logic [4:0]  ras_count;

    modport master (
        output pc_in, start, stall, branch_taken, branch_off, jump, call, jump_target, ret, halt,
        input  pcnext_out, imem_req, done, ras_overflow, ras_underflow, state_dbg, ras_count
    );

    modport slave (
        input  pc_in, start, stall, branch_taken, branch_off, jump, call, jump_target, ret, halt,
        output pcnext_out, imem_req, done, ras_overflow, ras_underflow, state_dbg, ras_count
    );
endinterface

// File: rtl/fetch_seq.sv
// Next-PC sequencer with an IDLE/RUN/HALTED control FSM and a circular return-address stack.
// The next-PC mux is combinational so that redirects add no latency.
module fetch_seq #(
    parameter int          RAS_DEPTH  = 4,
    parameter logic [15:0] START_ADDR = 16'h0000
) (
    input logic        CLK,
    input logic        reset_ctrl,
    fetch_seq_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q;
    logic [15:0]       ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              imem_req_q;
    logic              done_q;

    logic [PTR_W-1:0]  top_ptr;
    logic [15:0]       ras_top;
    logic [15:0]       pc_inc;
    logic [15:0]       br_off_ext;
    logic              ras_empty;
    logic              ras_full;
    logic              in_run;
    logic              do_ret;
    logic              do_call;
    logic [15:0]       pcnext_d;

    assign top_ptr    = wr_ptr_q - 1'b1;
    assign ras_top    = ras_q[top_ptr];
    assign pc_inc     = bus.pc_in + 16'd1;
    assign br_off_ext = {{8{bus.branch_off[7]}}, bus.branch_off};
    assign ras_empty  = (count_q == '0);
    assign ras_full   = (count_q == (PTR_W+1)'(RAS_DEPTH));
    assign in_run     = (state_q == ST_RUN);

    // halt and stall freeze the stack; ret beats call in the same cycle
    assign do_ret  = in_run && !bus.halt && !bus.stall && bus.ret;
    assign do_call = in_run && !bus.halt && !bus.stall && !bus.ret && bus.call;

    always_comb begin
        pcnext_d = START_ADDR;
        unique case (state_q)
            ST_IDLE:   pcnext_d = START_ADDR;
            ST_HALTED: pcnext_d = bus.pc_in;
            ST_RUN: begin
                if (bus.halt || bus.stall)      pcnext_d = bus.pc_in;
                else if (bus.ret)               pcnext_d = ras_empty ? pc_inc : ras_top;
                else if (bus.call || bus.jump)  pcnext_d = bus.jump_target;
                else if (bus.branch_taken)      pcnext_d = bus.pc_in + br_off_ext;
                else                            pcnext_d = pc_inc;
            end
            default:   pcnext_d = START_ADDR;
        endcase
    end

    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            imem_req_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 16'h0000;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_RUN;
                        imem_req_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.halt) begin
                        state_q    <= ST_HALTED;
                        imem_req_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (do_ret) begin
                if (ras_empty) begin
                    underflow_q <= 1'b1;
                end else begin
                    wr_ptr_q <= top_ptr;
                    count_q  <= count_q - 1'b1;
                end
            end else if (do_call) begin
                // when full, wr_ptr already points at the oldest entry
                ras_q[wr_ptr_q] <= pc_inc;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                if (ras_full) overflow_q <= 1'b1;
                else          count_q    <= count_q + 1'b1;
            end
        end
    end

    assign bus.pcnext_out    = pcnext_d;
    assign bus.imem_req      = imem_req_q;
    assign bus.done          = done_q;
    assign bus.ras_overflow  = overflow_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.state_dbg     = state_q;
    assign bus.ras_count     = 5'(count_q);
endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_seq;
    localparam int          DEPTH = 4;
    localparam logic [15:0] START = 16'h0A00;

    logic CLK = 1'b0;
    logic reset_ctrl;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    fetch_seq_if bus ();

    fetch_seq #(.RAS_DEPTH(DEPTH), .START_ADDR(START)) dut (
        .CLK        (CLK),
        .reset_ctrl (reset_ctrl),
        .bus        (bus)
    );

    // reference model: mode 0 = not started, 1 = running, 2 = stopped
    int          md;
    logic [15:0] ras_m [$];
    bit          ovf_m;
    bit          unf_m;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pc();
        logic [15:0] off;
        off = 16'($signed(bus.branch_off));
        if (md == 0) return START;
        if (md == 2) return bus.pc_in;
        if (bus.halt || bus.stall) return bus.pc_in;
        if (bus.ret) return (ras_m.size() > 0) ? ras_m[$] : bus.pc_in + 16'd1;
        if (bus.call || bus.jump) return bus.jump_target;
        if (bus.branch_taken) return bus.pc_in + off;
        return bus.pc_in + 16'd1;
    endfunction

    task automatic model_edge();
        logic [15:0] tmp;
        if (md == 0) begin
            if (bus.start) md = 1;
        end else if (md == 1) begin
            if (bus.halt) md = 2;
            else if (bus.stall) ;
            else if (bus.ret) begin
                if (ras_m.size() > 0) tmp = ras_m.pop_back();
                else unf_m = 1;
            end else if (bus.call) begin
                ras_m.push_back(bus.pc_in + 16'd1);
                if (ras_m.size() > DEPTH) begin
                    tmp = ras_m.pop_front();
                    ovf_m = 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        md = 0;
        ras_m.delete();
        ovf_m = 0;
        unf_m = 0;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_off = 8'h00;
        bus.jump = 0; bus.call = 0; bus.jump_target = 16'h0000; bus.ret = 0; bus.halt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".pcnext"}, bus.pcnext_out, model_pc());
        check_eq({tag, ".imem_req"}, 16'(bus.imem_req), 16'(md == 1));
        check_eq({tag, ".done"}, 16'(bus.done), 16'(md == 2));
        check_eq({tag, ".ovf"}, 16'(bus.ras_overflow), 16'(ovf_m));
        check_eq({tag, ".unf"}, 16'(bus.ras_underflow), 16'(unf_m));
        check_eq({tag, ".count"}, 16'(bus.ras_count), 16'(ras_m.size()));
    endtask

    // called just after a falling edge with inputs already driven
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic async_reset(input string tag);
        #2 reset_ctrl = 1'b1;
        #1;
        check_eq({tag, ".pcnext"}, bus.pcnext_out, START);
        check_eq({tag, ".imem_req"}, 16'(bus.imem_req), 16'd0);
        check_eq({tag, ".done"}, 16'(bus.done), 16'd0);
        check_eq({tag, ".ovf"}, 16'(bus.ras_overflow), 16'd0);
        check_eq({tag, ".unf"}, 16'(bus.ras_underflow), 16'd0);
        check_eq({tag, ".count"}, 16'(bus.ras_count), 16'd0);
        model_reset();
        clear_inputs();
        @(negedge CLK);
        reset_ctrl = 1'b0;
    endtask

    task automatic start_run();
        clear_inputs();
        bus.start = 1;
        cycle("start");
        bus.start = 0;
    endtask

    initial begin
        reset_ctrl = 1'b1;
        clear_inputs();
        bus.pc_in = 16'h0000;
        model_reset();
        @(negedge CLK);
        check_outputs("reset");
        check_eq("reset.pcnext_abs", bus.pcnext_out, START);
        reset_ctrl = 1'b0;

        // control inputs ignored before start
        bus.jump = 1; bus.jump_target = 16'h1234; bus.halt = 1; bus.pc_in = 16'h0077;
        cycle("idle_ignore");
        start_run();

        bus.pc_in = 16'h0010;
        #1 check_eq("seq_abs", bus.pcnext_out, 16'h0011);
        check_eq("seq_req", 16'(bus.imem_req), 16'd1);
        cycle("seq");
        bus.pc_in = 16'hFFFF;
        cycle("seq_wrap");

        bus.pc_in = 16'h0020; bus.branch_taken = 1; bus.branch_off = 8'hF0;
        #1 check_eq("br_neg_abs", bus.pcnext_out, 16'h0010);
        cycle("br_neg");
        bus.branch_off = 8'h7F;
        #1 check_eq("br_pos_abs", bus.pcnext_out, 16'h009F);
        cycle("br_pos");
        clear_inputs();

        bus.pc_in = 16'h0005; bus.call = 1; bus.jump_target = 16'h0100;
        #1 check_eq("call_abs", bus.pcnext_out, 16'h0100);
        cycle("call");
        clear_inputs();
        bus.pc_in = 16'h0103; bus.ret = 1;
        #1 check_eq("ret_abs", bus.pcnext_out, 16'h0006);
        cycle("ret");
        clear_inputs();

        // overflow then drain past empty
        for (int i = 0; i < 5; i++) begin
            bus.pc_in = 16'h0200 + 16'(i * 16); bus.call = 1; bus.jump_target = 16'h0300;
            cycle("ovf_call");
        end
        #1 check_eq("ovf_abs", 16'(bus.ras_overflow), 16'd1);
        bus.call = 0;
        for (int i = 0; i < 5; i++) begin
            bus.pc_in = 16'h0400 + 16'(i); bus.ret = 1;
            #1 if (i < 4) check_eq("lifo_abs", bus.pcnext_out, 16'h0241 - 16'(i * 16));
            else          check_eq("unf_ret_abs", bus.pcnext_out, 16'h0405);
            cycle("drain");
        end
        #1 check_eq("unf_abs", 16'(bus.ras_underflow), 16'd1);
        clear_inputs();

        // ret wins over call
        bus.pc_in = 16'h0050; bus.call = 1; bus.ret = 1; bus.jump_target = 16'h0600;
        cycle("ret_vs_call");
        clear_inputs();

        bus.pc_in = 16'h0033; bus.stall = 1; bus.jump = 1; bus.jump_target = 16'h0999;
        #1 check_eq("stall_abs", bus.pcnext_out, 16'h0033);
        cycle("stall_jump");
        clear_inputs();

        bus.pc_in = 16'h0060; bus.call = 1; bus.jump_target = 16'h0700;
        cycle("pre_rst_call");
        bus.call = 1; bus.pc_in = 16'h0061;
        async_reset("rst_mid_run");
        bus.pc_in = 16'h0062;
        cycle("after_rst_idle");
        start_run();

        // halt beats call
        bus.pc_in = 16'h0008; bus.call = 1; bus.jump_target = 16'h0800;
        cycle("pre_halt_call");
        bus.pc_in = 16'h0040; bus.halt = 1; bus.call = 1;
        #1 check_eq("halt_abs", bus.pcnext_out, 16'h0040);
        cycle("halt_call");
        clear_inputs();
        #1 check_eq("halt_done_abs", 16'(bus.done), 16'd1);
        check_eq("halt_count_abs", 16'(bus.ras_count), 16'd1);
        bus.start = 1; bus.jump = 1; bus.jump_target = 16'h0123;
        cycle("halted_start");
        #1 check_eq("halted_stays", 16'(bus.done), 16'd1);
        async_reset("rst_halted");
        start_run();

        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            bus.pc_in        = 16'($urandom);
            bus.stall        = ($urandom_range(0, 7) == 0);
            bus.ret          = ($urandom_range(0, 3) == 0);
            bus.call         = ($urandom_range(0, 2) == 0);
            bus.jump         = ($urandom_range(0, 4) == 0);
            bus.branch_taken = ($urandom_range(0, 2) == 0);
            bus.branch_off   = 8'($urandom);
            bus.jump_target  = 16'($urandom);
            bus.halt         = ($urandom_range(0, 59) == 0);
            bus.start        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rnd_rst");
                start_run();
            end else begin
                cycle("rnd");
            end
            if (md == 2 && $urandom_range(0, 4) == 0) begin
                clear_inputs();
                async_reset("rnd_halt_rst");
                start_run();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
